// File: rtl/wait_event_multi.sv
// wait_event_multi: waits on one selected channel for rise/fall/eq/neq, then pulses done.
// Optional cycle timeout is built only when WAIT_EVENT_MULTI_TIMEOUT_EN is defined.
module wait_event_multi #(
    parameter int WAIT_SIZE  = 8,
    parameter int WAIT_WIDTH = 8,
    parameter int COUNT_W    = 8,
    parameter int TIMEOUT_W  = 16,
    parameter int SEL_W      = (WAIT_SIZE > 1) ? $clog2(WAIT_SIZE) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WAIT_WIDTH-1:0] i_wait [WAIT_SIZE],
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [SEL_W-1:0]      i_sel,
    input  logic [1:0]            i_mode,
    input  logic [WAIT_WIDTH-1:0] i_value,
    input  logic [COUNT_W-1:0]    i_count,
    input  logic [TIMEOUT_W-1:0]  i_timeout,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_timeout,
    output logic                  o_sel_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] M_RISE = 2'd0;
    localparam logic [1:0] M_FALL = 2'd1;
    localparam logic [1:0] M_EQ   = 2'd2;
    localparam logic [1:0] M_NEQ  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [1:0]            mode_q, mode_d;
    logic [WAIT_WIDTH-1:0] value_q, value_d;
    logic [COUNT_W-1:0]    count_q, count_d;
    logic [COUNT_W-1:0]    edge_cnt_q, edge_cnt_d;
    logic [WAIT_SIZE-1:0]  prev_q, prev_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  tmo_q, tmo_d;
    logic                  sel_err_q, sel_err_d;

    logic [WAIT_WIDTH-1:0] cur;
    logic                  cur_prev;
    logic                  rise;
    logic                  fall;
    logic                  edge_hit;
    logic                  level_hit;
    logic                  evt_done;
    logic                  tmo_hit;
    logic [COUNT_W-1:0]    edge_cnt_inc;

    always_comb begin
        prev_d = '0;
        for (int k = 0; k < WAIT_SIZE; k++) begin
            prev_d[k] = i_wait[k][0];
        end
    end

    always_comb begin
        cur      = '0;
        cur_prev = 1'b0;
        for (int k = 0; k < WAIT_SIZE; k++) begin
            if (int'(sel_q) == k) begin
                cur      = i_wait[k];
                cur_prev = prev_q[k];
            end
        end
    end

    assign rise = ~cur_prev & cur[0];
    assign fall = cur_prev & ~cur[0];

    always_comb begin
        edge_hit  = 1'b0;
        level_hit = 1'b0;
        case (mode_q)
            M_RISE:  edge_hit  = rise;
            M_FALL:  edge_hit  = fall;
            M_EQ:    level_hit = (cur == value_q);
            M_NEQ:   level_hit = (cur != value_q);
            default: level_hit = 1'b0;
        endcase
    end

    assign edge_cnt_inc = (edge_cnt_q == '1) ? edge_cnt_q
                                             : edge_cnt_q + COUNT_W'(1);
    assign evt_done = level_hit | (edge_hit & (edge_cnt_inc >= count_q));

`ifdef WAIT_EVENT_MULTI_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tlim_q, tlim_d;
    logic [TIMEOUT_W-1:0] cyc_q, cyc_d;
    logic [TIMEOUT_W-1:0] cyc_inc;

    assign cyc_inc = (cyc_q == '1) ? cyc_q : cyc_q + TIMEOUT_W'(1);
    assign tmo_hit = (tlim_q != '0) && (cyc_inc == tlim_q);
`else
    logic unused_timeout;

    assign unused_timeout = ^i_timeout;
    assign tmo_hit        = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        mode_d     = mode_q;
        value_d    = value_q;
        count_d    = count_q;
        edge_cnt_d = edge_cnt_q;
        done_d     = 1'b0;
        tmo_d      = 1'b0;
        sel_err_d  = 1'b0;
`ifdef WAIT_EVENT_MULTI_TIMEOUT_EN
        tlim_d     = tlim_q;
        cyc_d      = cyc_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    sel_d   = i_sel;
                    mode_d  = i_mode;
                    value_d = i_value;
                    count_d = (i_count == '0) ? COUNT_W'(1) : i_count;
`ifdef WAIT_EVENT_MULTI_TIMEOUT_EN
                    tlim_d  = i_timeout;
                    cyc_d   = '0;
`endif
                    edge_cnt_d = '0;
                    if (int'(i_sel) >= WAIT_SIZE) begin
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        sel_err_d = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (i_abort) begin
                    state_d = S_IDLE;
                end else begin
                    if (edge_hit) begin
                        edge_cnt_d = edge_cnt_inc;
                    end
`ifdef WAIT_EVENT_MULTI_TIMEOUT_EN
                    cyc_d = cyc_inc;
`endif
                    // a real event beats a timeout landing on the same cycle
                    if (evt_done) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else if (tmo_hit) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        tmo_d   = 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_WAIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sel_q      <= '0;
            mode_q     <= '0;
            value_q    <= '0;
            count_q    <= '0;
            edge_cnt_q <= '0;
            prev_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tmo_q      <= 1'b0;
            sel_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            mode_q     <= mode_d;
            value_q    <= value_d;
            count_q    <= count_d;
            edge_cnt_q <= edge_cnt_d;
            prev_q     <= prev_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tmo_q      <= tmo_d;
            sel_err_q  <= sel_err_d;
        end
    end

`ifdef WAIT_EVENT_MULTI_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tlim_q <= '0;
            cyc_q  <= '0;
        end else begin
            tlim_q <= tlim_d;
            cyc_q  <= cyc_d;
        end
    end
`endif

    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_timeout = tmo_q;
    assign o_sel_err = sel_err_q;

endmodule

// File: tb/tb_wait_event_multi.sv
// tb_wait_event_multi: directed and randomized checks of wait_event_multi
// against a command-level reference model kept in the bench.
module tb_wait_event_multi;

    localparam int WS = 8;
    localparam int WW = 8;
    localparam int CW = 8;
    localparam int TW = 16;
    localparam int SW = 4;

`ifdef WAIT_EVENT_MULTI_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    localparam logic [1:0] RISE = 2'd0;
    localparam logic [1:0] FALL = 2'd1;
    localparam logic [1:0] EQ   = 2'd2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [WW-1:0] wait_v [WS];
    logic          start;
    logic          abort;
    logic [SW-1:0] sel;
    logic [1:0]    mode;
    logic [WW-1:0] value;
    logic [CW-1:0] count;
    logic [TW-1:0] tmo;
    logic          busy;
    logic          done;
    logic          tmo_o;
    logic          serr;

    always #5 clk = ~clk;

    wait_event_multi #(
        .WAIT_SIZE (WS),
        .WAIT_WIDTH(WW),
        .COUNT_W   (CW),
        .TIMEOUT_W (TW),
        .SEL_W     (SW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_wait   (wait_v),
        .i_start  (start),
        .i_abort  (abort),
        .i_sel    (sel),
        .i_mode   (mode),
        .i_value  (value),
        .i_count  (count),
        .i_timeout(tmo),
        .o_busy   (busy),
        .o_done   (done),
        .o_timeout(tmo_o),
        .o_sel_err(serr)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // reference: one pending command, counted in plain integers
    bit       m_busy = 0;
    bit       e_done = 0;
    bit       e_tmo  = 0;
    bit       e_serr = 0;
    int       c_sel, c_need, c_tlim, hits, elapsed;
    logic [1:0]    c_mode;
    logic [WW-1:0] c_val;
    bit       m_prev [WS];

    int  n_done, first_done, busy_cyc;
    bit  last_tmo, last_serr;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h",
                     name, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        logic [WW-1:0] cur;
        bit ev;
        bit fin;
        if (!rst_n) begin
            m_busy = 0;
            e_done = 0;
            e_tmo  = 0;
            e_serr = 0;
            foreach (m_prev[k]) m_prev[k] = 0;
            return;
        end
        if (e_done) begin
            e_done = 0;
            e_tmo  = 0;
            e_serr = 0;
        end else if (!m_busy) begin
            if (start) begin
                if (int'(sel) >= WS) begin
                    e_done = 1;
                    e_serr = 1;
                end else begin
                    m_busy  = 1;
                    c_sel   = int'(sel);
                    c_mode  = mode;
                    c_val   = value;
                    c_need  = (count == 0) ? 1 : int'(count);
                    c_tlim  = TMO_EN ? int'(tmo) : 0;
                    hits    = 0;
                    elapsed = 0;
                end
            end
        end else if (abort) begin
            m_busy = 0;
        end else begin
            cur = wait_v[c_sel];
            ev = 0;
            if (c_mode == RISE) ev = !m_prev[c_sel] && cur[0];
            if (c_mode == FALL) ev = m_prev[c_sel] && !cur[0];
            if (ev) hits++;
            elapsed++;
            case (c_mode)
                2'd2:    fin = (cur == c_val);
                2'd3:    fin = (cur != c_val);
                default: fin = ev && (hits >= c_need);
            endcase
            if (fin) begin
                m_busy = 0;
                e_done = 1;
            end else if (c_tlim != 0 && elapsed == c_tlim) begin
                m_busy = 0;
                e_done = 1;
                e_tmo  = 1;
            end
        end
        foreach (m_prev[k]) m_prev[k] = wait_v[k][0];
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        check("busy", {31'b0, busy}, {31'b0, m_busy});
        check("done", {31'b0, done}, {31'b0, e_done});
        check("timeout", {31'b0, tmo_o}, {31'b0, e_tmo});
        check("sel_err", {31'b0, serr}, {31'b0, e_serr});
        if (done === 1'b1) begin
            n_done++;
            if (first_done < 0) first_done = cyc;
            last_tmo  = tmo_o;
            last_serr = serr;
        end
        if (busy === 1'b1) busy_cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic clr_mon();
        n_done     = 0;
        first_done = -1;
        busy_cyc   = 0;
        last_tmo   = 0;
        last_serr  = 0;
    endtask

    task automatic go(input int s, input logic [1:0] m, input logic [7:0] v,
                      input int c, input int t_lim, output int t);
        t     = cyc;
        sel   = SW'(s);
        mode  = m;
        value = v;
        count = CW'(c);
        tmo   = TW'(t_lim);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int t;
        int t2;
        start = 0;
        abort = 0;
        sel   = '0;
        mode  = '0;
        value = '0;
        count = '0;
        tmo   = '0;
        foreach (wait_v[k]) wait_v[k] = '0;
        clr_mon();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);

        // rise x3 on channel 2
        clr_mon();
        go(2, RISE, 8'h00, 3, 0, t);
        wait_to(t + 3);  wait_v[2] = 8'h01;
        wait_to(t + 5);  wait_v[2] = 8'h00;
        wait_to(t + 7);  wait_v[2] = 8'h01;
        wait_to(t + 9);  wait_v[2] = 8'h00;
        wait_to(t + 11); wait_v[2] = 8'h01;
        wait_to(t + 14);
        check("rise3_done_cycle", first_done, t + 12);
        check("rise3_ndone", n_done, 1);
        check("rise3_tmo", {31'b0, last_tmo}, 32'd0);
        check("rise3_busy_cycles", busy_cyc, 11);
        wait_v[2] = 8'h00;
        tick();

        // EQ 0xA5, arriving later
        clr_mon();
        go(0, EQ, 8'hA5, 0, 0, t);
        wait_to(t + 8); wait_v[0] = 8'hA5;
        wait_to(t + 11);
        check("eq_late_done_cycle", first_done, t + 9);
        check("eq_late_ndone", n_done, 1);

        // EQ already satisfied at start
        clr_mon();
        go(0, EQ, 8'hA5, 0, 0, t);
        wait_to(t + 4);
        check("eq_now_done_cycle", first_done, t + 2);
        check("eq_now_serr", {31'b0, last_serr}, 32'd0);
        wait_v[0] = 8'h00;
        tick();

        // FALL with no falling edge, timeout 20
        clr_mon();
        go(3, FALL, 8'h00, 1, 20, t);
`ifdef WAIT_EVENT_MULTI_TIMEOUT_EN
        wait_to(t + 23);
        check("tmo_done_cycle", first_done, t + 21);
        check("tmo_flag", {31'b0, last_tmo}, 32'd1);
        check("tmo_ndone", n_done, 1);
`else
        wait_to(t + 1001);
        check("notmo_ndone", n_done, 0);
        check("notmo_busy", {31'b0, busy}, 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'd0);
        repeat (3) tick();
        check("abort_ndone", n_done, 0);
`endif

        // invalid channel index
        clr_mon();
        go(9, RISE, 8'h00, 1, 0, t);
        wait_to(t + 3);
        check("selerr_done_cycle", first_done, t + 1);
        check("selerr_flag", {31'b0, last_serr}, 32'd1);
        check("selerr_busy_cycles", busy_cyc, 0);

        // event and timeout on the same cycle, plus an ignored restart
        clr_mon();
        go(1, RISE, 8'h00, 1, 4, t);
        wait_to(t + 2);
        sel   = SW'(0);
        mode  = EQ;
        value = 8'h00;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_to(t + 4); wait_v[1] = 8'h01;
        wait_to(t + 9);
        check("tie_done_cycle", first_done, t + 5);
        check("tie_tmo", {31'b0, last_tmo}, 32'd0);
        check("tie_ndone", n_done, 1);
        wait_v[1] = 8'h00;
        tick();

        // reset mid-wait
        clr_mon();
        go(4, RISE, 8'h00, 1, 0, t);
        wait_to(t + 3);
        check("pre_reset_busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", {28'b0, busy, done, tmo_o, serr}, 32'd0);
        wait_to(t + 5);
        rst_n = 1'b1;
        clr_mon();
        wait_to(t + 6); wait_v[4] = 8'h01;
        wait_to(t + 12);
        check("post_reset_ndone", n_done, 0);
        check("post_reset_busy", busy_cyc, 0);
        wait_v[4] = 8'h00;
        tick();
        clr_mon();
        go(4, RISE, 8'h00, 1, 0, t2);
        wait_to(t2 + 2); wait_v[4] = 8'h01;
        wait_to(t2 + 5);
        check("post_reset_cmd", first_done, t2 + 3);

        // randomized traffic checked every cycle by the model
        clr_mon();
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom % 5) == 0;
            abort = ($urandom % 40) == 0;
            sel   = SW'($urandom_range(0, 9));
            mode  = 2'($urandom % 4);
            value = WW'($urandom % 4);
            count = CW'($urandom % 4);
            tmo   = TW'($urandom_range(0, 12));
            foreach (wait_v[k]) begin
                if (($urandom % 3) == 0) wait_v[k] = WW'($urandom % 4);
            end
            if ((i % 1000) == 999) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
        repeat (5) tick();
        check("rand_dones_seen", {31'b0, n_done > 0}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
